// File: rtl/reload_down_counter.sv
// reload_down_counter: N-bit down counter with reload register, one-shot/auto-reload and tc pulse.
// Optional prescaler enabled by defining RELOAD_DOWN_COUNTER_PRESCALE_EN.
module reload_down_counter #(
    parameter int N = 10
`ifdef RELOAD_DOWN_COUNTER_PRESCALE_EN
    , parameter int PRESCALE_W = 8
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_en,
    input  logic [N-1:0]          load_val,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  auto_reload,
`ifdef RELOAD_DOWN_COUNTER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale_div,
`endif
    output logic [N-1:0]          count,
    output logic                  tc,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [N-1:0] count_q, count_d, reload_q, reload_d, r_new;
    logic tc_q, tc_d, busy_q, busy_d, done_q, done_d, tick;
`ifdef RELOAD_DOWN_COUNTER_PRESCALE_EN
    logic [PRESCALE_W-1:0] pre_q, pre_d;
    assign tick  = pre_q == prescale_div;
    assign pre_d = (state_q != RUN || stop || start || tick) ? '0 : pre_q + 1'b1;
`else
    assign tick = 1'b1;
`endif
    always_comb begin
        r_new    = load_en ? load_val : reload_q;
        reload_d = r_new;
        state_d  = state_q;
        count_d  = count_q;
        tc_d     = 1'b0;
        if (state_q == RUN) begin
            if (stop) state_d = IDLE;
            else if (start) count_d = r_new;
            else if (tick) begin
                // a load in this same cycle only affects later reloads
                if (count_q != '0) count_d = count_q - 1'b1;
                else begin
                    tc_d    = 1'b1;
                    count_d = auto_reload ? reload_q : '0;
                    state_d = auto_reload ? RUN : DONE;
                end
            end
        end else if (stop) state_d = IDLE;
        else if (start) begin
            count_d = r_new;
            state_d = RUN;
        end else if (load_en) count_d = load_val;
        busy_d = state_d == RUN;
        done_d = state_d == DONE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef RELOAD_DOWN_COUNTER_PRESCALE_EN
            pre_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef RELOAD_DOWN_COUNTER_PRESCALE_EN
            pre_q    <= pre_d;
`endif
        end
    end
    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = busy_q;
    assign done  = done_q;
endmodule

// File: tb/tb_reload_down_counter.sv
// tb_reload_down_counter: vector table, corner sequences and random run against a behavioural model.
module tb_reload_down_counter;
    logic clk = 1'b0, reset = 1'b0;
    logic load_en = 1'b0, start = 1'b0, stop = 1'b0, auto_reload = 1'b0;
    logic [9:0] load_val = '0;
    logic [9:0] count;
    logic tc, busy, done;
`ifdef RELOAD_DOWN_COUNTER_PRESCALE_EN
    logic [7:0] prescale_div = '0;
`endif
    int compared = 0, mismatched = 0;

    always #5 clk = ~clk;

    reload_down_counter dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_val(load_val),
        .start(start), .stop(stop), .auto_reload(auto_reload),
`ifdef RELOAD_DOWN_COUNTER_PRESCALE_EN
        .prescale_div(prescale_div),
`endif
        .count(count), .tc(tc), .busy(busy), .done(done)
    );

    // model: mode 0 = idle, 1 = counting, 2 = finished
    int m_mode = 0;
    int m_count = 0, m_reload = 0;
    bit m_tc = 0;

    task automatic model_reset();
        m_mode = 0; m_count = 0; m_reload = 0; m_tc = 0;
    endtask

    task automatic model_step();
        int r_new;
        bit fire;
        r_new = load_en ? int'(load_val) : m_reload;
        fire = 0;
        if (m_mode == 1) begin
            if (stop) m_mode = 0;
            else if (start) m_count = r_new;
            else if (m_count > 0) m_count = m_count - 1;
            else begin
                fire = 1;
                if (auto_reload) m_count = m_reload;
                else m_mode = 2;
            end
        end else if (stop) m_mode = 0;
        else if (start) begin
            m_count = r_new;
            m_mode = 1;
        end else if (load_en) m_count = int'(load_val);
        m_reload = r_new;
        m_tc = fire;
    endtask

    task automatic setin(input bit ld, input int lv, input bit st, input bit sp, input bit ar);
        load_en = ld; load_val = 10'(lv); start = st; stop = sp; auto_reload = ar;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk(input string name, input int ec, input bit etc, input bit eb, input bit ed);
        compared++;
        if ({count, tc, busy, done} !== {10'(ec), etc, eb, ed}) begin
            mismatched++;
            $display("FAIL %s: got count=%0d tc=%b busy=%b done=%b, want count=%0d tc=%b busy=%b done=%b",
                     name, count, tc, busy, done, ec, etc, eb, ed);
        end
    endtask

    task automatic chkm(input string name);
        chk(name, m_count, m_tc, m_mode == 1, m_mode == 2);
    endtask

    task automatic chkv(input string name, input int got, input int exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    typedef struct {
        bit ld; int lv; bit st, sp, ar;
        int ec; bit etc, eb, ed;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t v(bit ld, int lv, bit st, bit sp, bit ar, int ec, bit etc, bit eb, bit ed);
        vec_t r;
        r.ld = ld; r.lv = lv; r.st = st; r.sp = sp; r.ar = ar;
        r.ec = ec; r.etc = etc; r.eb = eb; r.ed = ed;
        return r;
    endfunction

    initial begin
        // one-shot R=5
        tbl.push_back(v(1, 5, 0, 0, 0, 5, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 0, 5, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 4, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 3, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 2, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0));
        // auto-reload R=3, then stop at count 2
        tbl.push_back(v(1, 3, 0, 0, 1, 3, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 1, 3, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 2, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 3, 1, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 2, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 3, 1, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 2, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 1, 2, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 2, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 1, 1, 2, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 2, 0, 0, 0));
        // R=0 auto-reload, stop suppressing tc, then R=0 one-shot
        tbl.push_back(v(1, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 1, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, 1, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 0, 1, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1));

        repeat (5) @(posedge clk);
        #1 chk("reset", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();

        foreach (tbl[i]) begin
            setin(tbl[i].ld, tbl[i].lv, tbl[i].st, tbl[i].sp, tbl[i].ar);
            step();
            chk($sformatf("vec%0d", i), tbl[i].ec, tbl[i].etc, tbl[i].eb, tbl[i].ed);
        end

        // reload value changed mid-period: current period ends, later ones use R=2
        setin(1, 8, 0, 0, 1); step(); chkm("ld8");
        setin(0, 0, 1, 0, 1); step(); chkm("start8");
        setin(0, 0, 0, 0, 1);
        repeat (4) begin step(); chkm("run8"); end
        setin(1, 2, 0, 0, 1); step(); chk("run_load", 3, 0, 1, 0);
        setin(0, 0, 0, 0, 1);
        for (int i = 1; i <= 12; i++) begin
            step();
            chkm("after_load");
            chkv($sformatf("tc_after_load%0d", i), int'(tc), int'(i == 4 || i == 7 || i == 10));
        end
        setin(0, 0, 0, 1, 0); step(); chkm("stop2");

        // maximum reload: first tc 1024 ticks after start
        setin(1, 1023, 1, 0, 0); step(); chk("rmax_start", 1023, 0, 1, 0);
        setin(0, 0, 0, 0, 0);
        begin
            int n = 0;
            for (int i = 0; i < 1100; i++) begin
                step();
                chkm("rmax");
                n++;
                if (tc) break;
            end
            chkv("rmax_period", n, 1024);
        end

        // asynchronous reset while running
        setin(1, 20, 1, 0, 1); step(); chkm("pre_reset");
        setin(0, 0, 0, 0, 1);
        repeat (3) begin step(); chkm("pre_reset_run"); end
        #2 reset = 1'b0;
        #1 chk("async_reset", 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        step(); chkm("post_reset");

        for (int i = 0; i < 3000; i++) begin
            setin($urandom % 8 == 0, ($urandom % 4 == 0) ? int'($urandom % 1024) : int'($urandom % 6),
                  $urandom % 12 == 0, $urandom % 16 == 0, $urandom % 2 == 1);
            step();
            chkm("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
